// File: rtl/scm_rf_arb_pkg.sv
// rtl/scm_rf_arb_pkg.sv - shared helpers for the register file port arbiter
package scm_rf_arb_pkg;

  // Index width for an N-entry selector; a single entry still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with enable-gated pointer advance
module rr_arbiter
  import scm_rf_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] idx;
  logic          valid;

  // Pick the first requester at or above the pointer, else wrap to the lowest one below it.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req_i[i] && (IW'(i) >= ptr_q)) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid && req_i[i] && (IW'(i) < ptr_q)) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

  // One-hot grant for the winner.
  always_comb begin
    gnt_o = '0;
    if (valid) gnt_o[idx] = 1'b1;
  end

  // Pointer moves past the winner only when the grant is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i && valid) ptr_d = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign idx_o   = idx;
  assign valid_o = valid;

endmodule

// File: rtl/scm_rf_port_arbiter.sv
// rtl/scm_rf_port_arbiter.sv - shares a 1R/1W register file between many requesters
module scm_rf_port_arbiter
  import scm_rf_arb_pkg::*;
#(
  parameter int N_RD       = 4,
  parameter int N_WR       = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_RD-1:0]              rd_req_i,
  input  logic [N_RD*ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [N_RD-1:0]              rd_gnt_o,
  output logic [N_RD-1:0]              rd_rvalid_o,
  output logic [DATA_WIDTH-1:0]        rd_rdata_o,
  input  logic [N_WR-1:0]              wr_req_i,
  input  logic [N_WR*ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [N_WR*DATA_WIDTH-1:0]   wr_wdata_i,
  output logic [N_WR-1:0]              wr_gnt_o,
  output logic                         rf_read_enable_o,
  output logic [ADDR_WIDTH-1:0]        rf_read_addr_o,
  input  logic [DATA_WIDTH-1:0]        rf_read_data_i,
  output logic                         rf_write_enable_o,
  output logic [ADDR_WIDTH-1:0]        rf_write_addr_o,
  output logic [DATA_WIDTH-1:0]        rf_write_data_o
);

  localparam int RW = idx_width(N_RD);
  localparam int WW = idx_width(N_WR);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  addr_t rd_addr_arr [N_RD];
  addr_t wr_addr_arr [N_WR];
  data_t wr_data_arr [N_WR];

  for (genvar g = 0; g < N_RD; g++) begin : g_rd_unpack
    assign rd_addr_arr[g] = rd_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
  end
  for (genvar g = 0; g < N_WR; g++) begin : g_wr_unpack
    assign wr_addr_arr[g] = wr_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data_arr[g] = wr_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [WW-1:0]   wr_idx;
  logic            wr_valid;
  logic [N_RD-1:0] rd_gnt_raw;
  logic [RW-1:0]   rd_idx;
  logic            rd_valid;
  logic            collision;
  logic            rd_granted;

  logic            rsp_valid_q;
  logic            rsp_valid_d;
  logic [RW-1:0]   rsp_id_q;
  logic [RW-1:0]   rsp_id_d;

  // Writes are never held off, so their pointer always advances on a grant.
  rr_arbiter #(.N(N_WR)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (wr_req_i),
    .en_i    (1'b1),
    .gnt_o   (wr_gnt_o),
    .idx_o   (wr_idx),
    .valid_o (wr_valid)
  );

  // A read blocked by the guard keeps its pointer so the same requester goes first next cycle.
  rr_arbiter #(.N(N_RD)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (rd_req_i),
    .en_i    (!collision),
    .gnt_o   (rd_gnt_raw),
    .idx_o   (rd_idx),
    .valid_o (rd_valid)
  );

  // Same-address read/write in one cycle: the write wins so both RAM flavours behave alike.
  always_comb begin
    collision = wr_valid && rd_valid && (rd_addr_arr[rd_idx] == wr_addr_arr[wr_idx]);
  end

  assign rd_granted = rd_valid && !collision;

  // Register file controls, forced to zero when idle to keep X off the RAM pins.
  always_comb begin
    rd_gnt_o          = rd_granted ? rd_gnt_raw : '0;
    rf_read_enable_o  = rd_granted;
    rf_read_addr_o    = rd_granted ? rd_addr_arr[rd_idx] : '0;
    rf_write_enable_o = wr_valid;
    rf_write_addr_o   = wr_valid ? wr_addr_arr[wr_idx] : '0;
    rf_write_data_o   = wr_valid ? wr_data_arr[wr_idx] : '0;
  end

  // Remember who was granted so the data returning next cycle can be steered.
  always_comb begin
    rsp_valid_d = rd_granted;
    rsp_id_d    = rd_granted ? rd_idx : rsp_id_q;
  end

  // Response tracking registers; reset drops any outstanding response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // Per-requester valid decode; data is a shared pass-through bus.
  always_comb begin
    rd_rvalid_o = '0;
    for (int i = 0; i < N_RD; i++) begin
      rd_rvalid_o[i] = rsp_valid_q && (rsp_id_q == RW'(i));
    end
  end

  assign rd_rdata_o = rf_read_data_i;

endmodule

// File: tb/tb_scm_rf_port_arbiter.sv
// tb/tb_scm_rf_port_arbiter.sv - self-checking bench for scm_rf_port_arbiter
module tb_scm_rf_port_arbiter;

  localparam int N_RD = 4;
  localparam int N_WR = 2;
  localparam int AW   = 5;
  localparam int DW   = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N_RD-1:0]    rd_req_i;
  logic [N_RD*AW-1:0] rd_addr_i;
  logic [N_RD-1:0]    rd_gnt_o;
  logic [N_RD-1:0]    rd_rvalid_o;
  logic [DW-1:0]      rd_rdata_o;
  logic [N_WR-1:0]    wr_req_i;
  logic [N_WR*AW-1:0] wr_addr_i;
  logic [N_WR*DW-1:0] wr_wdata_i;
  logic [N_WR-1:0]    wr_gnt_o;
  logic               rf_read_enable_o;
  logic [AW-1:0]      rf_read_addr_o;
  logic [DW-1:0]      rf_read_data_i;
  logic               rf_write_enable_o;
  logic [AW-1:0]      rf_write_addr_o;
  logic [DW-1:0]      rf_write_data_o;

  scm_rf_port_arbiter #(
    .N_RD(N_RD), .N_WR(N_WR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rd_req_i          (rd_req_i),
    .rd_addr_i         (rd_addr_i),
    .rd_gnt_o          (rd_gnt_o),
    .rd_rvalid_o       (rd_rvalid_o),
    .rd_rdata_o        (rd_rdata_o),
    .wr_req_i          (wr_req_i),
    .wr_addr_i         (wr_addr_i),
    .wr_wdata_i        (wr_wdata_i),
    .wr_gnt_o          (wr_gnt_o),
    .rf_read_enable_o  (rf_read_enable_o),
    .rf_read_addr_o    (rf_read_addr_o),
    .rf_read_data_i    (rf_read_data_i),
    .rf_write_enable_o (rf_write_enable_o),
    .rf_write_addr_o   (rf_write_addr_o),
    .rf_write_data_o   (rf_write_data_o)
  );

  // Register file: variant 0 reads old data on a same-address write, variant 1 writes through.
  logic [DW-1:0] rf_mem [32];
  logic [DW-1:0] rf_rdata;
  logic          init_mem;
  logic          variant;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 32; k++) rf_mem[k] <= DW'(k * 17);
    end else if (rf_write_enable_o) begin
      rf_mem[rf_write_addr_o] <= rf_write_data_o;
    end
    if (rf_read_enable_o) begin
      rf_rdata <= (variant && rf_write_enable_o && rf_write_addr_o == rf_read_addr_o)
                  ? rf_write_data_o : rf_mem[rf_read_addr_o];
    end
  end
  assign rf_read_data_i = rf_rdata;

  int passed = 0;
  int total  = 0;

  // Requester-side state and reference model.
  logic          rd_pend [N_RD];
  logic [AW-1:0] rd_a    [N_RD];
  logic          wr_pend [N_WR];
  logic [AW-1:0] wr_a    [N_WR];
  logic [DW-1:0] wr_d    [N_WR];
  logic [DW-1:0] ref_mem [32];
  int            m_rd_ptr, m_wr_ptr;
  logic          m_rsp_v;
  int            m_rsp_id;
  logic [DW-1:0] m_rsp_data;
  logic [N_RD-1:0] obs_rd_gnt;
  logic [N_WR-1:0] obs_wr_gnt;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int rr_pick(input logic [7:0] mask, input int n, input int ptr);
    for (int k = 0; k < n; k++) begin
      if (mask[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N_RD; i++) begin
      rd_req_i[i] = rd_pend[i];
      rd_addr_i[i*AW +: AW] = rd_a[i];
    end
    for (int i = 0; i < N_WR; i++) begin
      wr_req_i[i] = wr_pend[i];
      wr_addr_i[i*AW +: AW] = wr_a[i];
      wr_wdata_i[i*DW +: DW] = wr_d[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N_RD; i++) begin rd_pend[i] = 1'b0; rd_a[i] = '0; end
    for (int i = 0; i < N_WR; i++) begin wr_pend[i] = 1'b0; wr_a[i] = '0; wr_d[i] = '0; end
  endtask

  task automatic model_reset();
    m_rd_ptr = 0;
    m_wr_ptr = 0;
    m_rsp_v  = 1'b0;
    m_rsp_id = 0;
  endtask

  // One clock cycle: drive at negedge, check outputs against the model, then advance the model.
  task automatic cycle();
    logic [7:0] rmask, wmask;
    int w, r;
    logic col;
    logic [N_RD-1:0] exp_rg;
    logic [N_WR-1:0] exp_wg;
    drive();
    #1;
    rmask = '0;
    wmask = '0;
    for (int i = 0; i < N_RD; i++) rmask[i] = rd_pend[i];
    for (int i = 0; i < N_WR; i++) wmask[i] = wr_pend[i];
    w = rr_pick(wmask, N_WR, m_wr_ptr);
    r = rr_pick(rmask, N_RD, m_rd_ptr);
    col = (w >= 0) && (r >= 0) && (rd_a[r] == wr_a[w]);
    exp_wg = (w >= 0) ? N_WR'(1 << w) : '0;
    exp_rg = (r >= 0 && !col) ? N_RD'(1 << r) : '0;
    obs_rd_gnt = rd_gnt_o;
    obs_wr_gnt = wr_gnt_o;
    chk("wr_gnt", DW'(wr_gnt_o), DW'(exp_wg));
    chk("rd_gnt", DW'(rd_gnt_o), DW'(exp_rg));
    chk("rf_re", DW'(rf_read_enable_o), DW'(r >= 0 && !col));
    chk("rf_raddr", DW'(rf_read_addr_o), (r >= 0 && !col) ? DW'(rd_a[r]) : '0);
    chk("rf_we", DW'(rf_write_enable_o), DW'(w >= 0));
    chk("rf_waddr", DW'(rf_write_addr_o), (w >= 0) ? DW'(wr_a[w]) : '0);
    chk("rf_wdata", rf_write_data_o, (w >= 0) ? wr_d[w] : '0);
    chk("rvalid", DW'(rd_rvalid_o), m_rsp_v ? DW'(1 << m_rsp_id) : '0);
    if (m_rsp_v) chk("rdata", rd_rdata_o, m_rsp_data);
    if (r >= 0 && !col) begin
      m_rsp_v    = 1'b1;
      m_rsp_id   = r;
      m_rsp_data = ref_mem[rd_a[r]];
      m_rd_ptr   = (r + 1) % N_RD;
      rd_pend[r] = 1'b0;
    end else begin
      m_rsp_v = 1'b0;
    end
    if (w >= 0) begin
      ref_mem[wr_a[w]] = wr_d[w];
      m_wr_ptr   = (w + 1) % N_WR;
      wr_pend[w] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    init_mem = 1'b1;
    variant  = 1'b0;
    rd_req_i = '0; rd_addr_i = '0; wr_req_i = '0; wr_addr_i = '0; wr_wdata_i = '0;
    for (int k = 0; k < 32; k++) ref_mem[k] = DW'(k * 17);
    clear_reqs();
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    chk("reset_rvalid", DW'(rd_rvalid_o), '0);
    chk("reset_rd_gnt", DW'(rd_gnt_o), '0);
    chk("reset_wr_gnt", DW'(wr_gnt_o), '0);
    chk("reset_rf_re", DW'(rf_read_enable_o), '0);
    chk("reset_rf_we", DW'(rf_write_enable_o), '0);
    rst = 1'b0;
    cycle();

    // All readers requesting: strict rotation 0,1,2,3,0,1,2,3.
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N_RD; i++) begin rd_pend[i] = 1'b1; rd_a[i] = AW'(i); end
      cycle();
      chk("rr_seq", DW'(obs_rd_gnt), DW'(1 << (c % 4)));
    end
    clear_reqs();
    cycle();

    // Two writers to the same address, then read it back.
    wr_pend[0] = 1'b1; wr_a[0] = 5'd3; wr_d[0] = 64'hA;
    wr_pend[1] = 1'b1; wr_a[1] = 5'd3; wr_d[1] = 64'hB;
    cycle();
    chk("wr_seq0", DW'(obs_wr_gnt), DW'(2'b01));
    cycle();
    chk("wr_seq1", DW'(obs_wr_gnt), DW'(2'b10));
    rd_pend[0] = 1'b1; rd_a[0] = 5'd3;
    cycle();
    #1 chk("rd_addr3", rd_rdata_o, 64'hB);
    cycle();

    // Same-cycle collision on address 5, for both register file variants.
    for (int v = 0; v < 2; v++) begin
      variant = v[0];
      wr_pend[0] = 1'b1; wr_a[0] = 5'd5; wr_d[0] = (v == 0) ? 64'hDEAD : 64'hBEEF;
      rd_pend[1] = 1'b1; rd_a[1] = 5'd5;
      cycle();
      chk("col_blocked", DW'(obs_rd_gnt), '0);
      cycle();
      chk("col_retry", DW'(obs_rd_gnt), DW'(4'b0010));
      #1 chk("col_data", rd_rdata_o, (v == 0) ? 64'hDEAD : 64'hBEEF);
      cycle();
    end
    variant = 1'b0;

    // Different addresses in the same cycle: both proceed, read sees old data.
    rd_pend[2] = 1'b1; rd_a[2] = 5'd7;
    wr_pend[1] = 1'b1; wr_a[1] = 5'd8; wr_d[1] = 64'h1234;
    cycle();
    chk("nocol_rd", DW'(obs_rd_gnt), DW'(4'b0100));
    chk("nocol_wr", DW'(obs_wr_gnt), DW'(2'b10));
    #1 chk("nocol_data", rd_rdata_o, 64'h77);
    cycle();

    // Reset right after a read grant drops its response and rewinds pointers.
    rd_pend[3] = 1'b1; rd_a[3] = 5'd9;
    drive();
    #1 chk("mid_gnt", DW'(rd_gnt_o), DW'(4'b1000));
    #2 rst = 1'b1;
    @(posedge clk);
    #1 chk("rst_rvalid", DW'(rd_rvalid_o), '0);
    model_reset();
    clear_reqs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N_RD; i++) begin rd_pend[i] = 1'b1; rd_a[i] = AW'(10 + i); end
    cycle();
    chk("rst_ptr", DW'(obs_rd_gnt), DW'(4'b0001));
    clear_reqs();
    cycle();

    // Random traffic on a small address window to provoke collisions.
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) variant = 1'($urandom_range(1, 0));
      for (int i = 0; i < N_RD; i++) begin
        if (!rd_pend[i] && $urandom_range(1, 0) == 1) begin
          rd_pend[i] = 1'b1;
          rd_a[i] = AW'($urandom_range(7, 0));
        end
      end
      for (int i = 0; i < N_WR; i++) begin
        if (!wr_pend[i] && $urandom_range(1, 0) == 1) begin
          wr_pend[i] = 1'b1;
          wr_a[i] = AW'($urandom_range(7, 0));
          wr_d[i] = {$urandom(), $urandom()};
        end
      end
      cycle();
    end
    clear_reqs();
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/scm_rf_port_arbiter.md
Name: scm_rf_port_arbiter

Overview:
- Shares one 1-read/1-write SCM register file (2**ADDR_WIDTH x DATA_WIDTH, registered read data, 1-cycle read latency) between N_RD read requesters and N_WR write requesters.
- Uses independent round-robin arbitration per port and a read/write same-address collision guard, so results are identical for the block-RAM and distributed-RAM variants.
- Routes returned read data back to the granted requester.
- Sits between the compute/DMA masters of a cluster subsystem and the register file instance.

Parameters:
- N_RD, 4, number of read requesters (>=1)
- N_WR, 2, number of write requesters (>=1)
- ADDR_WIDTH, 5, register file address width
- DATA_WIDTH, 64, register file data width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- rd_req_i  in  N_RD  read request per requester
- rd_addr_i  in  N_RD*ADDR_WIDTH  read address per requester (packed, index 0 in LSBs)
- rd_gnt_o  out  N_RD  read grant (one-hot or zero)
- rd_rvalid_o  out  N_RD  read data valid, one cycle after grant
- rd_rdata_o  out  DATA_WIDTH  read data, shared bus, qualified by rd_rvalid_o
- wr_req_i  in  N_WR  write request per requester
- wr_addr_i  in  N_WR*ADDR_WIDTH  write address per requester
- wr_wdata_i  in  N_WR*DATA_WIDTH  write data per requester
- wr_gnt_o  out  N_WR  write grant (one-hot or zero)
- rf_read_enable_o  out  1  to register file ReadEnable
- rf_read_addr_o  out  ADDR_WIDTH  to register file ReadAddr
- rf_read_data_i  in  DATA_WIDTH  from register file ReadData
- rf_write_enable_o  out  1  to register file WriteEnable
- rf_write_addr_o  out  ADDR_WIDTH  to register file WriteAddr
- rf_write_data_o  out  DATA_WIDTH  to register file WriteData

Behaviour:
- Reset values:
  - rr pointers = 0
  - rd_rvalid_o = 0
  - response id register = 0
  - rd_rdata_o = rf_read_data_i (combinational pass-through)
  - grants and rf controls are combinational, so they are 0 whenever no request is pending.
- Handshake:
  - Requester holds req and addr (and wdata) stable until it sees gnt; the transfer completes in the gnt cycle.
  - Dropping req before gnt is legal; no state is kept.
- Write arbitration (same cycle, combinational):
  - Round-robin over wr_req_i starting at wr_ptr.
  - Winner w gets wr_gnt_o[w]=1, rf_write_enable_o=1, addr/data muxed from w.
  - On grant, wr_ptr <= (w+1) mod N_WR.
- Read arbitration:
  - Round-robin over rd_req_i starting at rd_ptr, giving candidate r.
  - Collision guard: if a write is granted this cycle and rd_addr[r] == granted write addr, no read is granted this cycle. rd_gnt_o=0, rf_read_enable_o=0, rd_ptr unchanged. Write wins; r retries next cycle and reads the new data.
  - Otherwise rd_gnt_o[r]=1, rf_read_enable_o=1, rf_read_addr_o=rd_addr[r], and rd_ptr <= (r+1) mod N_RD.
- Response:
  - rsp_valid_q <= read granted; rsp_id_q <= r.
  - rd_rvalid_o[i] = rsp_valid_q && rsp_id_q==i.
  - Data is rf_read_data_i in that cycle. Latency is exactly 1 cycle after gnt.
  - Back-to-back reads: one per cycle, throughput 1.
- Write then read, same address, consecutive cycles: no stall; the read returns the written data (memory is updated at the write edge).
- With rf_read_enable_o=0 and no write, rf_read_addr_o holds 0 and rf_write_* hold 0 (no X propagation).
- Reset mid-operation: an outstanding response is dropped (rvalid not asserted) and pointers return to 0. Requesters must reissue.
- N_RD==1 or N_WR==1: pointer width is 1 bit and stays 0; the guard logic is unchanged.

Decomposition:
- Package scm_rf_arb_pkg:
  - function to compute index widths ($clog2 with minimum 1)
  - typedefs for addr_t/data_t are parameterised locally, not in the package
- Sub-module rr_arbiter #(N): inputs req[N], en; outputs gnt[N] one-hot, idx, valid; internal pointer register with asynchronous active-high reset, advancing only when en && valid.
- Instantiated twice: write with en=1, read with en=!collision.

Test Plan:
- Reset, no requests -> all gnt/rvalid 0, rf_read_enable_o=0, rf_write_enable_o=0.
- rd_req=4'b1111 held 8 cycles, mem[k]=k*0x11 -> grants cycle 0,1,2,3,0,1,2,3; rvalid one cycle later with matching data.
- wr_req=2'b11 to addr 3 with data 0xA/0xB -> wr_gnt 01 then 10; a later read of addr 3 returns 0xB.
- Same cycle: write addr 5 data 0xDEAD, read req addr 5 -> rd_gnt=0, then granted next cycle, rvalid returns 0xDEAD. Repeat with the distributed-RAM register file variant; results are identical.
- Read addr 7 and write addr 8 in the same cycle -> both granted; read returns old mem[7].
- Assert rst the cycle after a read grant -> rd_rvalid_o stays 0; after release, rd_ptr=0 so requester 0 wins the first tie.
